synthesis: RTL and testbench

- Top-level board-demo wrapper for the FFT hardware on the Altera DE0 (50 MHz).
- Generates a 4-point complex test frame from the switch settings and computes the 4-point radix-2 DIT FFT with a multiplier-free butterfly sequencer.
- Drives the selected bin's real part, imaginary part, or magnitude onto the 8 LEDs.
- Runs continuously, so the LEDs track the switches.

---
 rtl/synthesis.sv | 190 +++++++++++++++++++
 tb/tb_synthesis.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/synthesis.sv
// DE0 board demo: switch-driven 4-point test frame, multiplier-free radix-2 DIT FFT, selected bin on LEDs.
// Optional MAG_DISPLAY_EN: Im select shows L1 magnitude |Re|+|Im| instead of Im.
module synthesis #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] SW,
  output logic [7:0] LED
);

  localparam int unsigned SW_W  = 8;
  localparam int unsigned LED_W = 8;
  localparam int unsigned DW    = 10;
  localparam int unsigned NPT   = 4;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_S1A    = 3'd1,
    ST_S1B    = 3'd2,
    ST_S2A    = 3'd3,
    ST_S2B    = 3'd4,
    ST_UPDATE = 3'd5
  } state_t;

  function automatic cplx_t cadd(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re + b.re;
    r.im = a.im + b.im;
    return r;
  endfunction

  function automatic cplx_t csub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = a.re - b.re;
    r.im = a.im - b.im;
    return r;
  endfunction

  // -j * (re + j*im) = im - j*re : swap and negate, no multiplier
  function automatic cplx_t cmul_mj(input cplx_t b);
    cplx_t r;
    r.re = b.im;
    r.im = DW'(0) - b.re;
    return r;
  endfunction

`ifdef MAG_DISPLAY_EN
  function automatic logic [DW-1:0] cabs(input logic [DW-1:0] v);
    return v[DW-1] ? (DW'(0) - v) : v;
  endfunction
`endif

  logic [SW_W-1:0]  sync_q [SYNC_STAGES];
  logic [SW_W-1:0]  ssw;
  state_t           state_q, state_d;
  cplx_t            x_q   [NPT];
  cplx_t            x_d   [NPT];
  cplx_t            a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  cplx_t            res_q [NPT];
  cplx_t            res_d [NPT];
  cplx_t            bank_q [NPT];
  cplx_t            bank_d [NPT];
  logic [LED_W-1:0] led_q, led_d;

  logic [DW-1:0]    amp, amp2, amp3, amp_neg;
  cplx_t            cur;

  // Switch synchronizer; ssw is the last stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= SW;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ssw     = sync_q[SYNC_STAGES-1];
  assign amp     = DW'(ssw[2:0]);
  assign amp2    = amp << 1;
  assign amp3    = amp2 + amp;
  assign amp_neg = DW'(0) - amp;

  // Frame sequencer and butterfly datapath
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    res_d   = res_q;
    bank_d  = bank_q;
    unique case (state_q)
      ST_LOAD: begin
        for (int n = 0; n < int'(NPT); n++) x_d[n] = '0;
        unique case (ssw[5:4])
          2'd0: for (int n = 0; n < int'(NPT); n++) x_d[n].re = amp;
          2'd1: x_d[0].re = amp;
          2'd2: begin
            x_d[0].re = amp;
            x_d[1].re = amp_neg;
            x_d[2].re = amp;
            x_d[3].re = amp_neg;
          end
          default: begin
            x_d[1].re = amp;
            x_d[2].re = amp2;
            x_d[3].re = amp3;
          end
        endcase
        state_d = ST_S1A;
      end
      ST_S1A: begin
        a0_d    = cadd(x_q[0], x_q[2]);
        a1_d    = csub(x_q[0], x_q[2]);
        state_d = ST_S1B;
      end
      ST_S1B: begin
        b0_d    = cadd(x_q[1], x_q[3]);
        b1_d    = csub(x_q[1], x_q[3]);
        state_d = ST_S2A;
      end
      ST_S2A: begin
        res_d[0] = cadd(a0_q, b0_q);
        res_d[2] = csub(a0_q, b0_q);
        state_d  = ST_S2B;
      end
      ST_S2B: begin
        res_d[1] = cadd(a1_q, cmul_mj(b1_q));
        res_d[3] = csub(a1_q, cmul_mj(b1_q));
        state_d  = ST_UPDATE;
      end
      ST_UPDATE: begin
        bank_d  = res_q;
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Display mux reads the output bank with the live bin/select switches
  always_comb begin
    cur = bank_q[ssw[7:6]];
    if (!ssw[3]) begin
      led_d = cur.re[LED_W-1:0];
    end else begin
`ifdef MAG_DISPLAY_EN
      led_d = LED_W'(cabs(cur.re) + cabs(cur.im));
`else
      led_d = cur.im[LED_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      led_q   <= '0;
      for (int n = 0; n < int'(NPT); n++) begin
        x_q[n]    <= '0;
        res_q[n]  <= '0;
        bank_q[n] <= '0;
      end
    end else begin
      state_q <= state_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      led_q   <= led_d;
      x_q     <= x_d;
      res_q   <= res_d;
      bank_q  <= bank_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_synthesis.sv
// Self-checking bench for synthesis: DFT-from-definition model plus hand-computed LED literals.
module tb_synthesis;

  localparam int SYNC = 2;
  localparam int SETTLE = 16;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] led;

  int checks   = 0;
  int failures = 0;

  // 0 = idle, 1 = strict model match, 2 = either old or new frame value
  int         cmp_mode = 0;
  logic [7:0] sw_ref   = '0;
  logic [7:0] sw_old   = '0;

  synthesis #(.SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .reset(reset),
    .SW   (sw),
    .LED  (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LED value from the DFT definition X[k] = sum x[n]*(-j)^(n*k)
  function automatic logic [7:0] model_led(input logic [7:0] s);
    int a, p, k, re, im, m;
    int x [4];
    a = int'(s[2:0]);
    p = int'(s[5:4]);
    k = int'(s[7:6]);
    for (int n = 0; n < 4; n++) begin
      case (p)
        0:       x[n] = a;
        1:       x[n] = (n == 0) ? a : 0;
        2:       x[n] = (n % 2 == 1) ? -a : a;
        default: x[n] = n * a;
      endcase
    end
    re = 0;
    im = 0;
    for (int n = 0; n < 4; n++) begin
      m = (n * k) % 4;
      case (m)
        0:       re += x[n];
        1:       im -= x[n];
        2:       re -= x[n];
        default: im += x[n];
      endcase
    end
    if (s[3] == 1'b0) return 8'(re);
`ifdef MAG_DISPLAY_EN
    return 8'(((re < 0) ? -re : re) + ((im < 0) ? -im : im));
`else
    return 8'(im);
`endif
  endfunction

  always @(negedge clk) begin
    if (cmp_mode != 0) begin
      checks++;
      if (cmp_mode == 1) begin
        if (led !== model_led(sw_ref)) begin
          failures++;
          $display("FAIL model sw=%02h got=%02h exp=%02h", sw_ref, led, model_led(sw_ref));
        end
      end else if (led !== model_led(sw_ref) && led !== model_led(sw_old)) begin
        failures++;
        $display("FAIL glitch sw=%02h->%02h got=%02h exp=%02h or %02h",
                 sw_old, sw_ref, led, sw_old == sw_ref ? 8'h00 : model_led(sw_old), model_led(sw_ref));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [7:0] exp);
    checks++;
    if (led !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h", name, led, exp);
    end
  endtask

  task automatic apply_settle(input logic [7:0] s);
    sw     = s;
    sw_ref = s;
    step(SETTLE);
    cmp_mode = 1;
    step(2);
    cmp_mode = 0;
  endtask

  localparam int NLIT = 15;
  logic [7:0] lit_sw  [NLIT] = '{8'h08, 8'h07, 8'h47, 8'h15, 8'h55, 8'h95, 8'hD5, 8'h1D,
                                 8'hA3, 8'h23, 8'h37, 8'h77, 8'h7F, 8'hB7, 8'hFF};
`ifdef MAG_DISPLAY_EN
  logic [7:0] lit_exp [NLIT] = '{8'h00, 8'h1C, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05,
                                 8'h0C, 8'h00, 8'h2A, 8'hF2, 8'h1C, 8'hF2, 8'h1C};
`else
  logic [7:0] lit_exp [NLIT] = '{8'h00, 8'h1C, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'h00,
                                 8'h0C, 8'h00, 8'h2A, 8'hF2, 8'h0E, 8'hF2, 8'hF2};
`endif

  logic [7:0] gl_old [2] = '{8'h77, 8'h47};
  logic [7:0] gl_new [2] = '{8'h67, 8'h77};

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    sw    = 8'h37;
    step(3);
    check_lit("reset_hold", 8'h00);
    reset = 1'b1;
    sw    = 8'h00;

    // Hand-computed vectors
    for (int i = 0; i < NLIT; i++) begin
      apply_settle(lit_sw[i]);
      check_lit($sformatf("lit_sw%02h", lit_sw[i]), lit_exp[i]);
    end

    // Bin change alone reaches LED within SYNC+1 cycles
    apply_settle(8'h37);
    sw = 8'h77;
    step(SYNC + 1);
    check_lit("k_latency", 8'hF2);

    // Reset mid-frame clears LED at once and empties the output bank
    apply_settle(8'h37);
    step(3);
    reset = 1'b0;
    #1;
    check_lit("reset_mid", 8'h00);
    step(1);
    reset = 1'b1;
    step(1);
    check_lit("bank_cleared", 8'h00);
    sw_ref = 8'h37;
    step(SETTLE);
    check_lit("after_reset", 8'h2A);

    // Switch change at each frame phase: LED shows only whole-frame values
    for (int g = 0; g < 2; g++) begin
      for (int off = 0; off < 6; off++) begin
        apply_settle(gl_old[g]);
        step(off);
        sw_old   = gl_old[g];
        sw_ref   = gl_new[g];
        sw       = gl_new[g];
        cmp_mode = 2;
        step(SETTLE);
        cmp_mode = 1;
        step(2);
        cmp_mode = 0;
        sw_old   = gl_new[g];
      end
    end

    // Sweep pattern/amplitude/bin/select against the model
    for (int p = 0; p < 4; p++)
      for (int ai = 0; ai < 4; ai++)
        for (int k = 0; k < 4; k++)
          for (int s = 0; s < 2; s++)
            apply_settle(8'((k << 6) | (p << 4) | (s << 3) | ((ai < 2) ? ai : ai + 4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
